// File: rtl/btn_pkg.sv
// Shared types and constants for the push-button conditioning slice.
package btn_pkg;
  typedef enum logic [1:0] {IDLE, CHK_PRESS, PRESSED, CHK_REL} btn_state_t;
  localparam int SYNC_STAGES = 2;
endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: synchronizer, debounce FSM and registered level/pulse outputs.
// BTN_REPEAT_EN adds auto-repeat press pulses while the button stays held.
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1250000,
  parameter int REPEAT_DELAY    = 62500000,
  parameter int REPEAT_PERIOD   = 12500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic level,
  output logic press,
  output logic rel
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_cfg_err
    $error("btn_debounce_ch: illegal timing parameters");
  end

  logic [SYNC_STAGES-1:0] sync;
  logic                   s2;
  btn_state_t             state, state_nxt;
  logic [CW-1:0]          cnt, cnt_nxt;
  logic                   level_nxt, press_nxt, rel_nxt;

  assign s2 = sync[SYNC_STAGES-1];

`ifdef BTN_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);
  localparam logic [RW-1:0] REP_FIRST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] REP_NEXT  = RW'(REPEAT_PERIOD - 1);
  logic [RW-1:0] rep, rep_nxt;
  logic          first, first_nxt;
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    level_nxt = level;
    press_nxt = 1'b0;
    rel_nxt   = 1'b0;
`ifdef BTN_REPEAT_EN
    rep_nxt   = rep;
    first_nxt = first;
`endif
    case (state)
      IDLE: if (s2) begin
        state_nxt = CHK_PRESS;
        cnt_nxt   = '0;
      end
      CHK_PRESS: if (!s2) begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end else if (cnt == CNT_LAST) begin
        state_nxt = PRESSED;
        cnt_nxt   = '0;
        level_nxt = 1'b1;
        press_nxt = 1'b1;
`ifdef BTN_REPEAT_EN
        rep_nxt   = '0;
        first_nxt = 1'b1;
`endif
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
      PRESSED: if (!s2) begin
        state_nxt = CHK_REL;
        cnt_nxt   = '0;
      end else begin
`ifdef BTN_REPEAT_EN
        // first repeat waits the long delay, later ones the short period
        if (rep == (first ? REP_FIRST : REP_NEXT)) begin
          press_nxt = 1'b1;
          rep_nxt   = '0;
          first_nxt = 1'b0;
        end else begin
          rep_nxt = rep + 1'b1;
        end
`endif
      end
      CHK_REL: if (s2) begin
        state_nxt = PRESSED;
        cnt_nxt   = '0;
`ifdef BTN_REPEAT_EN
        rep_nxt   = '0;
        first_nxt = 1'b1;
`endif
      end else if (cnt == CNT_LAST) begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        level_nxt = 1'b0;
        rel_nxt   = 1'b1;
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        level_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= '0;
      state <= IDLE;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
      rel   <= 1'b0;
`ifdef BTN_REPEAT_EN
      rep   <= '0;
      first <= 1'b1;
`endif
    end else begin
      sync  <= {sync[SYNC_STAGES-2:0], btn};
      state <= state_nxt;
      cnt   <= cnt_nxt;
      level <= level_nxt;
      press <= press_nxt;
      rel   <= rel_nxt;
`ifdef BTN_REPEAT_EN
      rep   <= rep_nxt;
      first <= first_nxt;
`endif
    end
  end
endmodule

// File: rtl/btn_conditioner.sv
// Board push-button input stage: N_BTN independent debounced channels.
// Define BTN_REPEAT_EN to enable auto-repeat press pulses on held buttons.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int N_BTN           = 4,
  parameter int DEBOUNCE_CYCLES = 1250000,
  parameter int REPEAT_DELAY    = 62500000,
  parameter int REPEAT_PERIOD   = 12500000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release
);
  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_ch (
      .clk  (clk),
      .rst_n(rst_n),
      .btn  (btn[i]),
      .level(btn_level[i]),
      .press(btn_press[i]),
      .rel  (btn_release[i])
    );
  end
endmodule
